// File: rtl/mpc_channel_kob.sv
// Per-channel keep-order buffer: takes out-of-order bank responses tagged with rob_id
// and returns them to the channel in allocation order.
module mpc_channel_kob #(
   parameter int         KOB_SIZE   = 8,
   parameter logic [1:0] CHANNEL_ID = 2'd0,
   parameter int         DATA_W     = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alloc_valid_i,
   output logic              alloc_ready_o,
   output logic [2:0]        alloc_id_o,
   input  logic              rc_valid_i,
   input  logic [DATA_W+4:0] rc_rsp_i,
   output logic              rc_ready_o,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_o,
   output logic [3:0]        occupancy_o,
   output logic              err_o
);

   localparam int IDX_W = $clog2(KOB_SIZE);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_PENDING = 2'd1,
      SLOT_DONE    = 2'd2
   } slot_e;

   slot_e             slot_q [KOB_SIZE];
   slot_e             slot_d [KOB_SIZE];
   logic [DATA_W-1:0] data_q [KOB_SIZE];
   logic [DATA_W-1:0] data_d [KOB_SIZE];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic              err_q, err_d;

   logic [1:0]        rc_chan_s;
   logic [2:0]        rc_rob_s;
   logic [IDX_W-1:0]  rc_idx_s;
   logic [DATA_W-1:0] rc_rdata_s;
   logic [IDX_W-1:0]  head_idx_s;
   logic [IDX_W-1:0]  tail_idx_s;
   logic              full_s;
   logic              alloc_fire_s;
   logic              fill_hit_s;
   logic              pop_fire_s;

   assign rc_chan_s  = rc_rsp_i[DATA_W+4:DATA_W+3];
   assign rc_rob_s   = rc_rsp_i[DATA_W+2:DATA_W];
   assign rc_idx_s   = rc_rob_s[IDX_W-1:0];
   assign rc_rdata_s = rc_rsp_i[DATA_W-1:0];

   assign head_idx_s = head_q[IDX_W-1:0];
   assign tail_idx_s = tail_q[IDX_W-1:0];

   // Full when indices match but the wrap bits differ; a same-cycle pop does not open a slot.
   assign full_s       = (head_idx_s == tail_idx_s) && (head_q[IDX_W] != tail_q[IDX_W]);
   assign alloc_fire_s = alloc_valid_i & ~full_s;
   assign fill_hit_s   = rc_valid_i && (rc_chan_s == CHANNEL_ID);
   assign pop_fire_s   = rsp_valid_o & rsp_ready_i;

   assign alloc_ready_o = ~full_s;
   assign alloc_id_o    = 3'(tail_idx_s);
   assign rc_ready_o    = 1'b1;
   assign rsp_valid_o   = (slot_q[head_idx_s] == SLOT_DONE);
   assign rsp_o         = data_q[head_idx_s];
   assign occupancy_o   = 4'(tail_q - head_q);
   assign err_o         = err_q;

   // Next-state for slots, data RAM, pointers and the sticky error flag.
   always_comb begin
      slot_d = slot_q;
      data_d = data_q;
      head_d = head_q;
      tail_d = tail_q;
      err_d  = err_q;
      if (fill_hit_s) begin
         if (slot_q[rc_idx_s] == SLOT_PENDING) begin
            slot_d[rc_idx_s] = SLOT_DONE;
            data_d[rc_idx_s] = rc_rdata_s;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         err_d = err_q;
      end
      if (pop_fire_s) begin
         slot_d[head_idx_s] = SLOT_FREE;
         head_d             = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end
      if (alloc_fire_s) begin
         slot_d[tail_idx_s] = SLOT_PENDING;
         tail_d             = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end
   end

   // State registers; reset discards every in-flight entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < KOB_SIZE; i++) begin
            slot_q[i] <= SLOT_FREE;
            data_q[i] <= {DATA_W{1'b0}};
         end
         head_q <= {PTR_W{1'b0}};
         tail_q <= {PTR_W{1'b0}};
         err_q  <= 1'b0;
      end else begin
         slot_q <= slot_d;
         data_q <= data_d;
         head_q <= head_d;
         tail_q <= tail_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_mpc_channel_kob.sv
// Bench for mpc_channel_kob: directed scenarios plus a randomized stream, all checked
// every cycle against a queue-based model of allocation order.
module tb_mpc_channel_kob;

   localparam logic [1:0] CH = 2'd1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         alloc_valid = 1'b0;
   logic         alloc_ready;
   logic [2:0]   alloc_id;
   logic         rc_valid = 1'b0;
   logic [132:0] rc_rsp = '0;
   logic         rc_ready;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [127:0] rsp_data;
   logic [3:0]   occupancy;
   logic         err;

   mpc_channel_kob #(.KOB_SIZE(8), .CHANNEL_ID(CH), .DATA_W(128)) dut (
      .clk_i(clk), .rst_i(rst),
      .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
      .rc_valid_i(rc_valid), .rc_rsp_i(rc_rsp), .rc_ready_o(rc_ready),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp_data),
      .occupancy_o(occupancy), .err_o(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: ids in allocation order, per-id state (0 free, 1 pending, 2 done) and data.
   int           mq[$];
   int           m_state[8];
   logic [127:0] m_data[8];
   int           m_next;
   bit           m_err;

   function automatic void m_reset();
      mq.delete();
      for (int i = 0; i < 8; i++) begin
         m_state[i] = 0;
         m_data[i]  = '0;
      end
      m_next = 0;
      m_err  = 1'b0;
   endfunction

   function automatic bit m_valid();
      return (mq.size() > 0) && (m_state[mq[0]] == 2);
   endfunction

   task automatic check_outputs();
      chk("alloc_ready", 128'(alloc_ready), 128'(mq.size() < 8));
      chk("alloc_id", 128'(alloc_id), 128'(m_next));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_valid()));
      if (m_valid()) chk("rsp_data", rsp_data, m_data[mq[0]]);
      chk("occupancy", 128'(occupancy), 128'(mq.size()));
      chk("err", 128'(err), 128'(m_err));
      chk("rc_ready", 128'(rc_ready), 128'(1));
   endtask

   // One clock cycle: drive, check current outputs, advance the model, step the clock.
   task automatic cyc(input bit av, input bit rv, input logic [1:0] ch, input int id,
                      input logic [127:0] d, input bit rr);
      bit pop;
      bit alc;
      alloc_valid = av;
      rc_valid    = rv;
      rc_rsp      = {ch, 3'(id), d};
      rsp_ready   = rr;
      check_outputs();
      pop = m_valid() && rr;
      alc = av && (mq.size() < 8);
      if (rv && ch == CH) begin
         if (m_state[id] == 1) begin
            m_state[id] = 2;
            m_data[id]  = d;
         end else begin
            m_err = 1'b1;
         end
      end
      if (pop) m_state[mq.pop_front()] = 0;
      if (alc) begin
         mq.push_back(m_next);
         m_state[m_next] = 1;
         m_next = (m_next + 1) % 8;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, CH, 0, '0, rr);
   endtask

   // Asynchronous reset asserted in mid-cycle, outputs checked before the next edge.
   task automatic do_reset();
      alloc_valid = 1'b0;
      rc_valid    = 1'b0;
      rsp_ready   = 1'b0;
      #2 rst = 1'b1;
      #1;
      m_reset();
      chk("rst_occupancy", 128'(occupancy), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_data", rsp_data, 128'(0));
      chk("rst_alloc_ready", 128'(alloc_ready), 128'(1));
      chk("rst_alloc_id", 128'(alloc_id), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   int           pend[$];
   int           issued;
   int           budget;
   bit           av;
   bit           rv;
   bit           rr;
   int           fid;
   logic [1:0]   fch;
   logic [127:0] fdat;

   initial begin
      m_reset();
      @(posedge clk);
      #1;
      do_reset();

      // In-order fill with ready always high.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, CH, 0, '0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, CH, i, 128'hA0 + 128'(i), 1'b1);
      idle(2, 1'b1);

      // Reverse fill: nothing leaves until slot 0 is filled.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, CH, 0, '0, 1'b1);
      for (int i = 3; i >= 1; i--) cyc(1'b0, 1'b1, CH, i, 128'hB0 + 128'(i), 1'b1);
      cyc(1'b0, 1'b1, CH, 0, 128'hB0, 1'b1);
      idle(5, 1'b1);

      // Full: refuse alloc even on the cycle a pop frees a slot.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, CH, 0, '0, 1'b0);
      cyc(1'b1, 1'b1, CH, 0, 128'hC0, 1'b0);
      cyc(1'b1, 1'b0, CH, 0, '0, 1'b1);
      chk("full_reopen_id", 128'(alloc_id), 128'(0));
      cyc(1'b1, 1'b0, CH, 0, '0, 1'b0);

      // Randomized stream across pointer wrap with back-pressure and foreign beats.
      issued = 0;
      budget = 0;
      while ((issued < 20 || mq.size() > 0) && budget < 2000) begin
         budget++;
         av = (issued < 20) && ($urandom_range(0, 2) != 0);
         if (av && mq.size() < 8) issued++;
         pend.delete();
         for (int i = 0; i < 8; i++) if (m_state[i] == 1) pend.push_back(i);
         rv   = 1'b0;
         fch  = CH;
         fid  = 0;
         fdat = {$urandom, $urandom, $urandom, $urandom};
         if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
            rv  = 1'b1;
            fid = pend[$urandom_range(0, pend.size() - 1)];
         end else if ($urandom_range(0, 4) == 0) begin
            rv  = 1'b1;
            fch = CH + 2'd1;
            fid = $urandom_range(0, 7);
         end
         rr = ($urandom_range(0, 3) != 0);
         cyc(av, rv, fch, fid, fdat, rr);
      end
      chk("stream_drained", 128'(mq.size()), 128'(0));
      chk("stream_err", 128'(err), 128'(0));

      // Errors: foreign channel ignored, fill of a FREE slot flags err.
      do_reset();
      cyc(1'b0, 1'b1, CH + 2'd2, 5, 128'hD5, 1'b1);
      cyc(1'b0, 1'b0, CH, 0, '0, 1'b1);
      cyc(1'b0, 1'b1, CH, 5, 128'hD5, 1'b1);
      idle(2, 1'b1);
      chk("err_sticky", 128'(err), 128'(1));

      // Reset mid-operation, then a stale fill hits a FREE slot.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, CH, 0, '0, 1'b0);
      cyc(1'b0, 1'b1, CH, 2, 128'hE2, 1'b0);
      chk("pre_rst_occupancy", 128'(occupancy), 128'(4));
      do_reset();
      cyc(1'b0, 1'b1, CH, 1, 128'hE1, 1'b1);
      idle(2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
